// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - execute-stage condition evaluation, flag register and retire counters
module cond_unit #(
    parameter int          CNT_WIDTH  = 16,
    parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ValidE,
    input  logic                 StallE,
    input  logic                 KillE,
    input  logic [3:0]           CondE,
    input  logic [1:0]           FlagWriteE,
    input  logic [3:0]           ALUFlags,
    input  logic                 RegWriteE,
    input  logic                 MemWriteE,
    input  logic                 PCSrcE,
    input  logic                 CntClr,
    output logic                 CondExE,
    output logic                 RegWriteGE,
    output logic                 MemWriteGE,
    output logic                 PCSrcGE,
    output logic [3:0]           Flags,
    output logic [CNT_WIDTH-1:0] ExecCount,
    output logic [CNT_WIDTH-1:0] SquashCount
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;
    logic retire;
    logic commit;

    assign {flag_n, flag_z, flag_c, flag_v} = Flags;

    // Evaluated on committed flags only; the instruction's own ALU flags never feed back.
    always_comb begin
        cond_pass = 1'b0;
        case (CondE)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign CondExE    = ValidE & ~KillE & cond_pass;
    assign RegWriteGE = RegWriteE & CondExE;
    assign MemWriteGE = MemWriteE & CondExE;
    assign PCSrcGE    = PCSrcE & CondExE;

    // A stalled instruction repeats, so it only takes effect on its final E cycle.
    assign retire = ValidE & ~StallE;
    assign commit = retire & CondExE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags <= FLAG_RESET;
        end else if (commit) begin
            if (FlagWriteE[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagWriteE[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ExecCount   <= '0;
            SquashCount <= '0;
        end else if (CntClr) begin
            ExecCount   <= '0;
            SquashCount <= '0;
        end else if (commit) begin
            if (ExecCount != CNT_MAX) ExecCount <= ExecCount + CNT_ONE;
        end else if (retire) begin
            if (SquashCount != CNT_MAX) SquashCount <= SquashCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - self-checking bench for cond_unit with a behavioural reference model
module tb_cond_unit;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          ValidE, StallE, KillE;
    logic [3:0]    CondE;
    logic [1:0]    FlagWriteE;
    logic [3:0]    ALUFlags;
    logic          RegWriteE, MemWriteE, PCSrcE, CntClr;
    logic          CondExE, RegWriteGE, MemWriteGE, PCSrcGE;
    logic [3:0]    Flags;
    logic [CW-1:0] ExecCount, SquashCount;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_flags;
    int         m_exec;
    int         m_squash;

    cond_unit #(.CNT_WIDTH(CW), .FLAG_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset),
        .ValidE(ValidE), .StallE(StallE), .KillE(KillE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
        .CntClr(CntClr),
        .CondExE(CondExE), .RegWriteGE(RegWriteGE), .MemWriteGE(MemWriteGE),
        .PCSrcGE(PCSrcGE), .Flags(Flags),
        .ExecCount(ExecCount), .SquashCount(SquashCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Odd codes are the complement of the even predicate above them; 1111 never executes.
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'b1111) return 1'b0;
        return base ^ cond[0];
    endfunction

    function automatic logic model_ex();
        return ValidE && !KillE && cond_ok(CondE, m_flags);
    endfunction

    task automatic idle();
        ValidE = 0; StallE = 0; KillE = 0; CondE = 4'b1110; FlagWriteE = 2'b00;
        ALUFlags = 4'b0000; RegWriteE = 0; MemWriteE = 0; PCSrcE = 0; CntClr = 0;
    endtask

    task automatic tick();
        logic       ex, ret;
        logic [3:0] nf;
        int         ne, ns;
        ex  = model_ex();
        ret = ValidE && !StallE;
        nf  = m_flags;
        if (ret && ex) begin
            if (FlagWriteE[1]) nf[3:2] = ALUFlags[3:2];
            if (FlagWriteE[0]) nf[1:0] = ALUFlags[1:0];
        end
        ne = m_exec;
        ns = m_squash;
        if (CntClr) begin
            ne = 0; ns = 0;
        end else if (ret && ex) begin
            ne = (m_exec < CMAX) ? m_exec + 1 : CMAX;
        end else if (ret) begin
            ns = (m_squash < CMAX) ? m_squash + 1 : CMAX;
        end
        @(posedge clk);
        m_flags = nf; m_exec = ne; m_squash = ns;
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        idle();
        ValidE = 1; CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = f;
        tick();
        idle();
    endtask

    task automatic clear_counts();
        idle();
        CntClr = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 0;
        m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        for (int i = 0; i < 4; i++) begin
            {ValidE, StallE, KillE, RegWriteE, MemWriteE, PCSrcE, CntClr} = 7'($urandom);
            CondE = 4'($urandom); FlagWriteE = 2'($urandom); ALUFlags = 4'($urandom);
            @(posedge clk); #1;
        end
        n_checks++;
        if (Flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", Flags); end
        n_checks++;
        if (ExecCount !== 0 || SquashCount !== 0) begin
            n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", ExecCount, SquashCount);
        end
        idle();
        ValidE = 1; CondE = 4'b0000; #1;
        n_checks++;
        if (CondExE !== 1'b0) begin n_fail++; $display("FAIL reset_eq got %b want 0", CondExE); end
        CondE = 4'b1110; #1;
        n_checks++;
        if (CondExE !== 1'b1) begin n_fail++; $display("FAIL reset_al got %b want 1", CondExE); end
        idle();
        @(posedge clk); #1;
        reset = 1;
        #2;
    endtask

    task automatic test_cmp_beq();
        idle();
        ValidE = 1; CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = 4'b0110;
        tick();
        n_checks++;
        if (Flags !== 4'b0110) begin n_fail++; $display("FAIL cmp_flags got %b want 0110", Flags); end
        CondE = 4'b0000; FlagWriteE = 2'b00; ALUFlags = 4'b0000; PCSrcE = 1; #1;
        n_checks++;
        if (PCSrcGE !== 1'b1) begin n_fail++; $display("FAIL beq_pcsrc got %b want 1", PCSrcGE); end
        tick();
        n_checks++;
        if (ExecCount !== 2) begin n_fail++; $display("FAIL beq_exec got %0d want 2", ExecCount); end
        idle();
    endtask

    task automatic test_partial_write();
        set_flags(4'b0000);
        ValidE = 1; CondE = 4'b1110; ALUFlags = 4'b1111; FlagWriteE = 2'b01;
        tick();
        n_checks++;
        if (Flags !== 4'b0011) begin n_fail++; $display("FAIL partial_cv got %b want 0011", Flags); end
        ALUFlags = 4'b1000; FlagWriteE = 2'b10;
        tick();
        n_checks++;
        if (Flags !== 4'b1011) begin n_fail++; $display("FAIL partial_nz got %b want 1011", Flags); end
        idle();
    endtask

    task automatic test_failed_cond();
        logic [3:0] fl [2] = '{4'b0000, 4'b0100};
        logic [3:0] cc [2] = '{4'b0000, 4'b1111};
        set_flags(4'b0000);
        clear_counts();
        for (int i = 0; i < 2; i++) begin
            set_flags(fl[i]);
            ValidE = 1; CondE = cc[i]; RegWriteE = 1; MemWriteE = 1; PCSrcE = 1;
            FlagWriteE = 2'b11; ALUFlags = 4'b1111; #1;
            n_checks++;
            if ({CondExE, RegWriteGE, MemWriteGE, PCSrcGE} !== 4'b0000) begin
                n_fail++;
                $display("FAIL fail_gate[%0d] got %b want 0000", i, {CondExE, RegWriteGE, MemWriteGE, PCSrcGE});
            end
            tick();
            n_checks++;
            if (Flags !== fl[i]) begin n_fail++; $display("FAIL fail_flags[%0d] got %b want %b", i, Flags, fl[i]); end
            n_checks++;
            if (SquashCount !== CW'(i + 1)) begin
                n_fail++; $display("FAIL fail_squash[%0d] got %0d want %0d", i, SquashCount, i + 1);
            end
            idle();
        end
    endtask

    task automatic test_stall_kill();
        set_flags(4'b0000);
        clear_counts();
        ValidE = 1; StallE = 1; CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (CondExE !== 1'b1) begin n_fail++; $display("FAIL stall_condex[%0d] got %b want 1", i, CondExE); end
            tick();
            n_checks++;
            if (Flags !== 4'b0000 || ExecCount !== 0) begin
                n_fail++; $display("FAIL stall_hold[%0d] got %b/%0d want 0000/0", i, Flags, ExecCount);
            end
        end
        StallE = 0;
        tick();
        n_checks++;
        if (Flags !== 4'b1010 || ExecCount !== 1) begin
            n_fail++; $display("FAIL stall_release got %b/%0d want 1010/1", Flags, ExecCount);
        end
        KillE = 1; ALUFlags = 4'b0101; #1;
        n_checks++;
        if (CondExE !== 1'b0) begin n_fail++; $display("FAIL kill_condex got %b want 0", CondExE); end
        tick();
        n_checks++;
        if (Flags !== 4'b1010 || SquashCount !== 1) begin
            n_fail++; $display("FAIL kill_commit got %b/%0d want 1010/1", Flags, SquashCount);
        end
        StallE = 1; RegWriteE = 1; #1;
        n_checks++;
        if (CondExE !== 1'b0 || RegWriteGE !== 1'b0) begin
            n_fail++; $display("FAIL stallkill_gate got %b%b want 00", CondExE, RegWriteGE);
        end
        tick();
        n_checks++;
        if (Flags !== 4'b1010 || ExecCount !== 1 || SquashCount !== 1) begin
            n_fail++;
            $display("FAIL stallkill_hold got %b/%0d/%0d want 1010/1/1", Flags, ExecCount, SquashCount);
        end
        idle();
    endtask

    task automatic test_saturation_clear();
        clear_counts();
        ValidE = 1; CondE = 4'b1110;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (ExecCount !== CW'(CMAX)) begin n_fail++; $display("FAIL sat_exec got %0d want %0d", ExecCount, CMAX); end
        CntClr = 1;
        tick();
        n_checks++;
        if (ExecCount !== 0 || SquashCount !== 0) begin
            n_fail++; $display("FAIL clr_priority got %0d/%0d want 0/0", ExecCount, SquashCount);
        end
        CntClr = 0; CondE = 4'b1111;
        for (int i = 0; i < 18; i++) tick();
        n_checks++;
        if (SquashCount !== CW'(CMAX)) begin n_fail++; $display("FAIL sat_squash got %0d want %0d", SquashCount, CMAX); end
        idle();
    endtask

    task automatic test_async_reset();
        set_flags(4'b1101);
        ValidE = 1; CondE = 4'b1110;
        tick();
        #2;
        reset = 0;
        m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        #1;
        n_checks++;
        if (Flags !== 4'b0000 || ExecCount !== 0) begin
            n_fail++; $display("FAIL async_reset got %b/%0d want 0000/0", Flags, ExecCount);
        end
        @(negedge clk);
        reset = 1;
        idle();
        @(posedge clk); #1;
        n_checks++;
        if (Flags !== 4'b0000) begin n_fail++; $display("FAIL reset_release got %b want 0000", Flags); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic exp_ex;
            ValidE     = ($urandom_range(3) != 0);
            StallE     = ($urandom_range(3) == 0);
            KillE      = ($urandom_range(7) == 0);
            CondE      = 4'($urandom);
            FlagWriteE = 2'($urandom);
            ALUFlags   = 4'($urandom);
            RegWriteE  = 1'($urandom);
            MemWriteE  = 1'($urandom);
            PCSrcE     = 1'($urandom);
            CntClr     = ($urandom_range(31) == 0);
            #1;
            exp_ex = model_ex();
            n_checks++;
            if ({CondExE, RegWriteGE, MemWriteGE, PCSrcGE} !==
                {exp_ex, RegWriteE & exp_ex, MemWriteE & exp_ex, PCSrcE & exp_ex}) begin
                n_fail++;
                $display("FAIL rand_gate[%0d] got %b want %b", i, {CondExE, RegWriteGE, MemWriteGE, PCSrcGE},
                         {exp_ex, RegWriteE & exp_ex, MemWriteE & exp_ex, PCSrcE & exp_ex});
            end
            tick();
            n_checks++;
            if (Flags !== m_flags || ExecCount !== CW'(m_exec) || SquashCount !== CW'(m_squash)) begin
                n_fail++;
                $display("FAIL rand_state[%0d] got %b/%0d/%0d want %b/%0d/%0d", i, Flags, ExecCount,
                         SquashCount, m_flags, m_exec, m_squash);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 0;
        test_reset();
        test_cmp_beq();
        test_partial_write();
        test_failed_cond();
        test_stall_kill();
        test_saturation_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
Execute-stage conditional-execution unit for the pipelined core, and the consumer of the ALU's {N,Z,C,V} flag bus. It holds the architectural flag register and evaluates each instruction's 4-bit condition field against the committed flags. It gates the instruction's side effects (register write, memory write, PC redirect) and commits new flags from the ALU. It also keeps saturating counters of executed and squashed instructions for debug.

Parameters:
CNT_WIDTH, 16, width of the executed/squashed performance counters
FLAG_RESET, 4'b0000, reset value of the flag register {N,Z,C,V}

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
ValidE  input  1  execute stage holds a real instruction (0 = bubble)
StallE  input  1  execute stage held this cycle; instruction repeats next cycle
KillE  input  1  instruction in E is squashed by the hazard unit (wrong-path)
CondE  input  4  condition field of instruction in E
FlagWriteE  input  2  [1] writes N,Z; [0] writes C,V
ALUFlags  input  4  {N,Z,C,V} from the ALU for the instruction in E
RegWriteE  input  1  ungated register-write request
MemWriteE  input  1  ungated memory-write request
PCSrcE  input  1  ungated PC-redirect request (branch or PC write)
CntClr  input  1  synchronous clear of both counters
CondExE  output  1  condition passed and instruction is live
RegWriteGE  output  1  RegWriteE & CondExE
MemWriteGE  output  1  MemWriteE & CondExE
PCSrcGE  output  1  PCSrcE & CondExE
Flags  output  4  committed flag register {N,Z,C,V}
ExecCount  output  CNT_WIDTH  instructions retired from E with condition true
SquashCount  output  CNT_WIDTH  instructions retired from E with condition false or killed

Behaviour:
- Flag vector ordering is always {N,Z,C,V} = bits [3:0], matching the ALU flag bus.
- Reset, asynchronous on reset=0: Flags=FLAG_RESET, ExecCount=0, SquashCount=0. The combinational outputs follow from inputs and Flags, so with ValidE=0 they are all 0.
- CondPass is combinational on the registered Flags, never on ALUFlags. An instruction's own flags do not affect its own condition.
- Condition codes:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: 0 (reserved, never executes).
- CondExE = ValidE & ~KillE & CondPass. It is independent of StallE; gated outputs may be asserted during a stall, and downstream registers are held by the stall.
- Retire = ValidE & ~StallE (one event per instruction, counted on its last E cycle).
- Flag update at the rising edge when Retire & CondExE:
  - FlagWriteE[1]=1: N,Z <= ALUFlags[3:2].
  - FlagWriteE[0]=1: C,V <= ALUFlags[1:0].
  - Unwritten bits hold. No update on stall, bubble, kill or failed condition.
- Latency: a flag write is visible one cycle later. Back-to-back CMP then BEQ in consecutive E cycles sees the CMP's flags.
- Counters, at the rising edge:
  - CntClr=1: both counters go to 0. This has priority over increment.
  - Else if Retire & CondExE: ExecCount+1.
  - Else if Retire & ~CondExE: SquashCount+1.
  - Both counters saturate at all-ones and never wrap.
- Simultaneous StallE & KillE: outputs are gated to 0 and nothing is committed or counted.
- Reset asserted mid-operation clears state immediately, regardless of clk. Release is synchronous to the next edge with no glitch on Flags.

Test Plan:
- Reset: hold reset=0 with random inputs -> Flags=0000, counters=0. With ValidE=1, CondE=0000 (EQ) -> CondExE=0; with CondE=1110 -> CondExE=1.
- CMP equal then BEQ: cycle0 ALUFlags=0110, FlagWriteE=11, CondE=1110, ValidE=1 -> Flags=0110 next cycle. Cycle1 CondE=0000, PCSrcE=1 -> PCSrcGE=1, ExecCount=2.
- Partial write: Flags=0000; ALUFlags=1111, FlagWriteE=01 -> Flags=0011. Then FlagWriteE=10 with ALUFlags=1000 -> Flags=1011.
- Failed condition and reserved code: Flags=0000, CondE=0000 with RegWriteE=MemWriteE=1 and FlagWriteE=11 -> all gated outputs 0, Flags unchanged, SquashCount+1. Repeat with CondE=1111 at Flags=0100 -> same result.
- Stall/kill: StallE=1 for 3 cycles with an AL instruction and FlagWriteE=11 -> CondExE=1 throughout; Flags and counters change once, on the cycle StallE falls. KillE=1 -> CondExE=0, SquashCount+1, no flag write.
- Saturation and clear: CNT_WIDTH=4, 20 retiring AL instructions -> ExecCount=15. CntClr=1 together with a retiring instruction -> ExecCount=0. Async reset pulse mid-stream -> Flags=FLAG_RESET immediately.
